// File: rtl/ikaopll_timing_pkg.sv
// Shared timing constants for the IKAOPLL cycle sequencer and its consumers.
// Slot numbers are 5-bit to match o_CYCLE_NUM.
package ikaopll_timing_pkg;

  localparam int unsigned FRAME_LEN_DEF = 18;

  localparam logic [4:0] SLOT_00   = 5'd0;
  localparam logic [4:0] SLOT_D3   = 5'd3;
  localparam logic [4:0] SLOT_D4   = 5'd4;
  localparam logic [4:0] SLOT_LAST = 5'(FRAME_LEN_DEF - 1);

  // Number of phi1 cycles the slot-3 strobe is delayed to form D3_ZZ.
  localparam int unsigned D3_DELAY = 2;

endpackage

// File: rtl/ikaopll_cen_div.sv
// Divides the master clock enable into the two-phase phi1 enables.
// NCEN fires at the half-period tick, PCEN at the end-of-period tick.
module ikaopll_cen_div #(
  parameter int unsigned PHI_DIV = 4
) (
  input  logic emuclk,
  input  logic i_RST_n,
  input  logic i_MCEN_n,
  output logic o_phi1_PCEN_n,
  output logic o_phi1_NCEN_n
);

  localparam int unsigned DW = (PHI_DIV > 2) ? $clog2(PHI_DIV) : 1;
  localparam logic [DW-1:0] DIV_NEG  = DW'(PHI_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(PHI_DIV - 1);

  logic          tick;
  logic [DW-1:0] div_q, div_d;

  always_comb begin
    tick  = ~i_MCEN_n;
    div_d = div_q;
    if (tick) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge emuclk) begin
    if (!i_RST_n) begin
      div_q         <= '0;
      o_phi1_NCEN_n <= 1'b1;
      o_phi1_PCEN_n <= 1'b1;
    end else begin
      div_q         <= div_d;
      o_phi1_NCEN_n <= ~(tick & (div_q == DIV_NEG));
      o_phi1_PCEN_n <= ~(tick & (div_q == DIV_LAST));
    end
  end

endmodule

// File: rtl/ikaopll_cycle_sequencer.sv
// Phi1 enable generation plus the per-frame slot counter and registered slot strobes.
// All strobes are decoded from the next counter value so they align with o_CYCLE_NUM.
module ikaopll_cycle_sequencer
  import ikaopll_timing_pkg::*;
#(
  parameter int unsigned PHI_DIV   = 4,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic       emuclk,
  input  logic       i_RST_n,
  input  logic       i_MCEN_n,
  input  logic       i_HOLD,
  output logic       o_phi1_PCEN_n,
  output logic       o_phi1_NCEN_n,
  output logic [4:0] o_CYCLE_NUM,
  output logic       o_CYCLE_00,
  output logic       o_CYCLE_17,
  output logic       o_CYCLE_D4,
  output logic       o_CYCLE_D3_ZZ,
  output logic       o_FRAME_STB
);

  localparam logic [4:0] LAST = 5'(FRAME_LEN - 1);

  ikaopll_cen_div #(
    .PHI_DIV(PHI_DIV)
  ) u_cen_div (
    .emuclk       (emuclk),
    .i_RST_n      (i_RST_n),
    .i_MCEN_n     (i_MCEN_n),
    .o_phi1_PCEN_n(o_phi1_PCEN_n),
    .o_phi1_NCEN_n(o_phi1_NCEN_n)
  );

  logic                adv;
  logic [4:0]          cyc_q, cyc_d;
  logic                c00_q, c17_q, d4_q, d3_q, stb_q;
  logic [D3_DELAY-1:0] d3_sr_q;

  always_comb begin
    adv   = ~o_phi1_NCEN_n & ~i_HOLD;
    cyc_d = (cyc_q == LAST) ? 5'd0 : cyc_q + 5'd1;
  end

  always_ff @(posedge emuclk) begin
    if (!i_RST_n) begin
      cyc_q   <= LAST;
      c00_q   <= 1'b0;
      c17_q   <= 1'b1;
      d4_q    <= 1'b0;
      d3_q    <= 1'b0;
      d3_sr_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (adv) begin
        cyc_q   <= cyc_d;
        c00_q   <= (cyc_d == SLOT_00);
        c17_q   <= (cyc_d == LAST);
        d4_q    <= (cyc_d == SLOT_D4);
        d3_q    <= (cyc_d == SLOT_D3);
        // Shift input is the registered slot-3 strobe, so the tap lands on slot 5.
        d3_sr_q <= {d3_sr_q[D3_DELAY-2:0], d3_q};
        stb_q   <= (cyc_d == SLOT_00);
      end
    end
  end

  always_comb begin
    o_CYCLE_NUM   = cyc_q;
    o_CYCLE_00    = c00_q;
    o_CYCLE_17    = c17_q;
    o_CYCLE_D4    = d4_q;
    o_CYCLE_D3_ZZ = d3_sr_q[D3_DELAY-1];
    o_FRAME_STB   = stb_q;
  end

endmodule
